// File: rtl/word_detector_if.sv
// Character stream bus for word_detector: X in, registered detect pulse and word code out,
// plus read-only matcher state for observation.
interface word_detector_if;
   logic [7:0] X;
   logic       Z;
   logic [2:0] Zout;
   logic [2:0] apple_st;
   logic [2:0] orange_st;
   logic [2:0] banana_st;

   // Handshake-free stream: one character per Clock edge, no valid/ready; the
   // master always presents X and the slave always produces Z/Zout.
   modport master (output X, input Z, Zout, apple_st, orange_st, banana_st);
   modport slave  (input X, output Z, Zout, apple_st, orange_st, banana_st);
endinterface

// File: rtl/word_detector.sv
// Keyword spotter for APPLE, ORANGE and BANANA on an 8-bit ASCII stream.
// Optional WORD_DETECTOR_CASE_INSENSITIVE_EN folds lower case to upper case before matching.
module word_detector (
   input  logic               Clock,
   input  logic               Reset,
   word_detector_if.slave     bus
);

   typedef enum logic [2:0] {A_S0, A_S1, A_S2, A_S3, A_S4} apple_state_e;
   typedef enum logic [2:0] {O_S0, O_S1, O_S2, O_S3, O_S4, O_S5} orange_state_e;
   typedef enum logic [2:0] {B_S0, B_S1, B_S2, B_S3, B_S4, B_S5} banana_state_e;

   apple_state_e  apple_q, apple_d;
   orange_state_e orange_q, orange_d;
   banana_state_e banana_q, banana_d;
   logic          z_q, z_d;
   logic [2:0]    zout_q, zout_d;
   logic [7:0]    ch;
   logic          apple_hit, orange_hit, banana_hit;

`ifdef WORD_DETECTOR_CASE_INSENSITIVE_EN
   assign ch = (bus.X >= 8'h61 && bus.X <= 8'h7A) ? bus.X - 8'h20 : bus.X;
`else
   assign ch = bus.X;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         apple_q  <= A_S0;
         orange_q <= O_S0;
         banana_q <= B_S0;
         z_q      <= 1'b0;
         zout_q   <= 3'd0;
      end else begin
         apple_q  <= apple_d;
         orange_q <= orange_d;
         banana_q <= banana_d;
         z_q      <= z_d;
         zout_q   <= zout_d;
      end
   end

   // Mismatch defaults restart on the word's first letter; only hits override them.
   always_comb begin
      apple_d   = (ch == "A") ? A_S1 : A_S0;
      apple_hit = 1'b0;
      case (apple_q)
         A_S0: if (ch == "A") apple_d = A_S1;
         A_S1: if (ch == "P") apple_d = A_S2;
         A_S2: if (ch == "P") apple_d = A_S3;
         A_S3: if (ch == "L") apple_d = A_S4;
         A_S4: if (ch == "E") apple_hit = 1'b1;
         default: apple_d = A_S0;
      endcase
   end

   always_comb begin
      orange_d   = (ch == "O") ? O_S1 : O_S0;
      orange_hit = 1'b0;
      case (orange_q)
         O_S0: if (ch == "O") orange_d = O_S1;
         O_S1: if (ch == "R") orange_d = O_S2;
         O_S2: if (ch == "A") orange_d = O_S3;
         O_S3: if (ch == "N") orange_d = O_S4;
         O_S4: if (ch == "G") orange_d = O_S5;
         O_S5: if (ch == "E") orange_hit = 1'b1;
         default: orange_d = O_S0;
      endcase
   end

   // A completed BANANA keeps "BANA" as a prefix so overlapping matches are found.
   always_comb begin
      banana_d   = (ch == "B") ? B_S1 : B_S0;
      banana_hit = 1'b0;
      case (banana_q)
         B_S0: if (ch == "B") banana_d = B_S1;
         B_S1: if (ch == "A") banana_d = B_S2;
         B_S2: if (ch == "N") banana_d = B_S3;
         B_S3: if (ch == "A") banana_d = B_S4;
         B_S4: if (ch == "N") banana_d = B_S5;
         B_S5: if (ch == "A") begin
            banana_hit = 1'b1;
            banana_d   = B_S4;
         end
         default: banana_d = B_S0;
      endcase
   end

   always_comb begin
      z_d    = apple_hit | orange_hit | banana_hit;
      zout_d = zout_q;
      if (banana_hit)      zout_d = 3'd3;
      else if (orange_hit) zout_d = 3'd2;
      else if (apple_hit)  zout_d = 3'd1;
   end

   assign bus.Z         = z_q;
   assign bus.Zout      = zout_q;
   assign bus.apple_st  = apple_q;
   assign bus.orange_st = orange_q;
   assign bus.banana_st = banana_q;

endmodule

// File: tb/tb_word_detector.sv
// Directed-vector bench for word_detector: each character carries a hand-computed Z and Zout
// expectation for the cycle after it is sampled.
module tb_word_detector;
   logic Clock;
   logic Reset;
   int   total;
   int   bad;

   word_detector_if bus ();

   word_detector dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clock = 1'b0;
   always #50 Clock = ~Clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one character, let one edge sample it, then inspect outputs mid-cycle.
   task automatic step(input string name, input logic [7:0] c, input logic ez,
                       input logic [2:0] ezout);
      bus.X = c;
      @(posedge Clock);
      #10;
      check($sformatf("%s_z_%c", name, c), {7'd0, bus.Z}, {7'd0, ez});
      check($sformatf("%s_zout_%c", name, c), {5'd0, bus.Zout}, {5'd0, ezout});
   endtask

   // z and zo are digit strings giving the expected Z and Zout after each character.
   task automatic run_str(input string name, input string s, input string z, input string zo);
      for (int i = 0; i < s.len(); i++) begin
         step(name, s[i], 1'(z[i] - "0"), 3'(zo[i] - "0"));
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      Reset    = 1'b1;
      bus.X    = 8'h00;
      #80;
      check("rst_z", {7'd0, bus.Z}, 8'd0);
      check("rst_zout", {5'd0, bus.Zout}, 8'd0);
      check("rst_apple_st", {5'd0, bus.apple_st}, 8'd0);
      check("rst_orange_st", {5'd0, bus.orange_st}, 8'd0);
      check("rst_banana_st", {5'd0, bus.banana_st}, 8'd0);
      Reset = 1'b0;

      run_str("abapples",  "ABAPPLES",  "00000010",  "00000011");
      run_str("porangest", "PORANGEST", "000000100", "111111222");
      run_str("wbananasa", "WBANANASA", "000000100", "222222333");
      run_str("bananana",  "BANANANA",  "00000101",  "33333333");
      run_str("nul",       "A",         "0",         "3");
      step("nul", 8'h00, 1'b0, 3'd3);
      check("nul_apple_st", {5'd0, bus.apple_st}, 8'd0);
      run_str("oe",        "APPLEORANGE", "00001000001", "33331111112");

      run_str("abort", "APP", "000", "222");
      check("abort_apple_st", {5'd0, bus.apple_st}, 8'd3);
      Reset = 1'b1;
      step("abort_rst", "L", 1'b0, 3'd0);
      check("abort_apple_st_rst", {5'd0, bus.apple_st}, 8'd0);
      Reset = 1'b0;
      run_str("abort", "LE", "00", "00");

`ifdef WORD_DETECTOR_CASE_INSENSITIVE_EN
      run_str("lower", "apple", "00001", "00001");
      run_str("mixed", "BaNaNa", "000001", "111113");
`else
      run_str("lower", "apple", "00000", "00000");
      run_str("mixed", "BaNaNa", "000000", "000000");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
